// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, segment constants and BCD range helper
// for the seg7_scan_mux display driver. Segments are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Largest decimal value that fits in n digits: 10^n - 1.
  function automatic logic [31:0] bcd_max(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r - 32'd1;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one bit per cycle.
// Ports: clk, rst (sync, high), start, bin[W-1:0] in; busy, done, bcd[W-1:0] out.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] bcd
);

  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  bin_q, bin_d;
  logic [W-1:0]  adj, bcd_n, bin_n;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_n, bin_n} = {adj, bin_q} << 1;
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bcd_d   = '0;
          bin_d   = bin;
        end
      end
      SHIFT: begin
        bcd_d = bcd_n;
        bin_d = bin_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done fires with the last shift so the result is taken the
  // same edge busy drops.
  assign busy = (state_q == SHIFT);
  assign done = busy && (cnt_q == CW'(W - 1));
  assign bcd  = bcd_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multi-digit 7-segment scan driver with shadow capture.
// In: clk, rst, value, load, dp_in, blank_in. Out: busy, sseg, dp_n, an, digit_tick.
// SEG7_SCAN_BCD_MODE_EN: treat value as binary and show it in decimal.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DIV_BITS      = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic                    busy,
  output logic [6:0]              sseg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    digit_tick
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d, idx_nxt, sel;
  logic                  first_q, first_d;
  logic [VW-1:0]         val_q, val_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  ovf_q, ovf_d;
  logic [6:0]            sseg_q, sseg_d;
  logic                  dpn_q, dpn_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_DIGITS-1:0] an_on;
  logic [3:0]            nib;
  logic                  sel_dp, sel_blank;
  logic                  wrap, upd;

`ifdef SEG7_SCAN_BCD_MODE_EN
  logic                  cv_busy, cv_done, cv_start;
  logic [VW-1:0]         cv_bcd;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  logic [NUM_DIGITS-1:0] pblank_q, pblank_d;
  logic                  povf_q, povf_d;

  assign cv_start = load & ~cv_busy;
  assign busy     = cv_busy;

  bin2bcd_seq #(.W(VW)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start),
    .bin   (value),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );
`else
  assign busy = 1'b0;
`endif

  assign wrap       = &div_q;
  assign digit_tick = wrap & ~rst;
  // Output regs resample only at a slot change (or the first cycle
  // after reset), so a capture never tears a slot in progress.
  assign upd        = wrap | first_q;

  always_comb begin
    idx_nxt = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    sel     = wrap ? idx_nxt : idx_q;
    nib       = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_on     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel == IW'(i)) begin
        nib       = val_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_blank = blank_q[i];
        an_on[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    div_d   = div_q + 1'b1;
    idx_d   = wrap ? idx_nxt : idx_q;
    first_d = 1'b0;
    sseg_d  = sseg_q;
    dpn_d   = dpn_q;
    an_d    = an_q;
    if (upd) begin
      if (sel_blank) begin
        sseg_d = SEG_BLANK;
        dpn_d  = 1'b1;
        an_d   = AN_OFF;
      end else begin
        sseg_d = ovf_q ? SEG_DASH : hex2seg(nib);
        dpn_d  = ~sel_dp;
        an_d   = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
      end
    end
    val_d   = val_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
`ifdef SEG7_SCAN_BCD_MODE_EN
    pdp_d    = pdp_q;
    pblank_d = pblank_q;
    povf_d   = povf_q;
    if (cv_start) begin
      pdp_d    = dp_in;
      pblank_d = blank_in;
      povf_d   = 32'(value) > bcd_max(NUM_DIGITS);
    end
    if (cv_done) begin
      val_d   = cv_bcd;
      dp_d    = pdp_q;
      blank_d = pblank_q;
      ovf_d   = povf_q;
    end
`else
    if (load) begin
      val_d   = value;
      dp_d    = dp_in;
      blank_d = blank_in;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      val_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      ovf_q    <= 1'b0;
      sseg_q   <= SEG_BLANK;
      dpn_q    <= 1'b1;
      an_q     <= AN_OFF;
`ifdef SEG7_SCAN_BCD_MODE_EN
      pdp_q    <= '0;
      pblank_q <= '0;
      povf_q   <= 1'b0;
`endif
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      val_q    <= val_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      ovf_q    <= ovf_d;
      sseg_q   <= sseg_d;
      dpn_q    <= dpn_d;
      an_q     <= an_d;
`ifdef SEG7_SCAN_BCD_MODE_EN
      pdp_q    <= pdp_d;
      pblank_q <= pblank_d;
      povf_q   <= povf_d;
`endif
    end
  end

  assign sseg = sseg_q;
  assign dp_n = dpn_q;
  assign an   = an_q;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised multi-digit 7-segment display driver; successor to the fixed 8-bit hex display block.
- Latches a value on a load strobe into a shadow register, time-multiplexes NUM_DIGITS digits with a programmable refresh prescaler, and drives active-low segments, decimal point and anodes.
- Sits between the datapath (sum or result registers) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIV_BITS, 16, prescaler width; each digit is held for 2^DIV_BITS clocks.
- AN_ACTIVE_LOW, 1, 1 = anodes active-low, 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  4*NUM_DIGITS  data to display, nibble i = digit i (digit 0 = rightmost)
- load  in  1  single-cycle strobe; captures value, dp_in and blank_in
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_in  in  NUM_DIGITS  1 = digit i dark
- busy  out  1  capture in progress; load is ignored while high
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
- digit_tick  out  1  one-cycle pulse when the scan index advances

Behaviour:
- Reset is synchronous: it clears the prescaler, the scan index, the shadow value, dp and blank masks, and busy.
  - During reset: sseg=7'h7F, dp_n=1, an all inactive, digit_tick=0.
- Prescaler counts 0..2^DIV_BITS-1 and wraps.
  - On wrap, digit_tick pulses for 1 cycle and the index advances (0..NUM_DIGITS-1, then back to 0).
- sseg, dp_n and an are registered, one cycle behind the index.
  - The first clock after reset release drives digit 0.
  - an is exactly one-hot on the current index, except when blank mask bit i=1: then all anodes are inactive and sseg=7'h7F for that slot.
- Hex encoding, nibble to sseg:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Capture without BCD: a load with busy=0 updates the shadow registers on the next edge, and busy stays 0.
  - The new value appears from the next scan slot onward. The slot in progress is never torn mid-slot: the output register samples the shadow only at the index change.
- load and the prescaler wrap in the same cycle: the capture and the advance both occur. The new slot shows the old shadow and the following slot shows the new one.
- Loads arriving faster than the scan are legal; the last load wins.
- Reset mid-scan or mid-capture aborts everything and returns to the reset state.

Optional Feature:
- Macro: SEG7_SCAN_BCD_MODE_EN.
- Defined: value is unsigned binary, converted to BCD by sequential double-dabble.
  - load with busy=0 latches value; busy goes high on the next cycle for 4*NUM_DIGITS cycles.
  - The shadow registers update atomically in the cycle busy falls.
  - If value > 10^NUM_DIGITS-1, every non-blanked digit shows dash (sseg=3F).
  - load while busy is dropped.
  - dp_in and blank_in are captured with the load, not at completion.
- Undefined: hex path only; busy is tied to 0 and the converter is absent.

Decomposition:
- Package seg7_pkg holds:
  - the hex-to-segment function
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F
  - a function for the maximum BCD value given the digit count
- One sub-module, bin2bcd_seq (shift/add-3 FSM with states IDLE, SHIFT, DONE; start/done handshake). It is instantiated only under SEG7_SCAN_BCD_MODE_EN.

Test Plan (NUM_DIGITS=4, DIV_BITS=2, so 4 clocks per digit):
1. Reset held 3 cycles, then released -> during reset an=4'hF and sseg=7F; 1 cycle after release an=4'hE and sseg shows nibble 0 of the shadow (0 -> 40); digit_tick period is 4 clocks.
2. load value=16'h00F4 -> successive slots show sseg 19 (4), 0E (F), 40, 40; an cycles E, D, B, 7 and wraps.
3. blank_in=4'b1100 with dp_in=4'b0001 on value=16'h1234 -> slots 0/1 show 19/30 with dp_n=0 only on slot 0; slots 2/3 have an=4'hF and sseg=7F.
4. load asserted in the same cycle as the prescaler wrap, old=0000 and new=FFFF -> the new slot shows 40 and the next slot shows 0E.
5. BCD_MODE_EN, load value=16'd1234 -> busy high for exactly 16 cycles and the shadow becomes 1234; a load during busy is ignored; value=16'd10000 -> all digits show 3F.
6. rst pulsed during BCD conversion (cycle 7) -> busy=0 next cycle, shadow=0, and outputs return to reset values.
